// File: rtl/id_fwd_stage_if.sv
// Decode/forward stage bus: upstream handshake, regfile read port, forwarding
// sources and the registered result toward EX. The DUT takes the slave view.
interface id_fwd_stage_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_FWD     = 3,
  parameter int unsigned STALL_CNT_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_inst;
  logic [XLEN-1:0]          in_pc;
  logic                     flush;
  logic [4:0]               rs1;
  logic [4:0]               rs2;
  logic [XLEN-1:0]          reg_a;
  logic [XLEN-1:0]          reg_b;
  logic [NUM_FWD-1:0]       fwd_valid;
  logic [NUM_FWD-1:0]       fwd_wb;
  logic [5*NUM_FWD-1:0]     fwd_rd;
  logic [NUM_FWD-1:0]       fwd_data_ok;
  logic [XLEN*NUM_FWD-1:0]  fwd_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_pc;
  logic [31:0]              out_inst;
  logic [XLEN-1:0]          out_rs1_val;
  logic [XLEN-1:0]          out_rs2_val;
  logic                     out_trap;
  logic [STALL_CNT_W-1:0]   stall_cnt;

  modport slave (
    input  in_valid, in_inst, in_pc, flush, reg_a, reg_b,
    input  fwd_valid, fwd_wb, fwd_rd, fwd_data_ok, fwd_data, out_ready,
    output in_ready, rs1, rs2, out_valid, out_pc, out_inst,
    output out_rs1_val, out_rs2_val, out_trap, stall_cnt
  );

  modport master (
    output in_valid, in_inst, in_pc, flush, reg_a, reg_b,
    output fwd_valid, fwd_wb, fwd_rd, fwd_data_ok, fwd_data, out_ready,
    input  in_ready, rs1, rs2, out_valid, out_pc, out_inst,
    input  out_rs1_val, out_rs2_val, out_trap, stall_cnt
  );
endinterface

// File: rtl/id_fwd_stage.sv
// RV32I decode/forward stage: decodes operand usage and traps, resolves rs1/rs2
// through priority-ordered forwarding sources, stalls on not-ready operands and
// registers the result behind a valid/ready output register.
module id_fwd_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_FWD     = 3,
  parameter int unsigned STALL_CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  id_fwd_stage_if.slave bus
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_use1;
  logic            w_use2;
  logic            w_trap;
  logic            w_hit1;
  logic            w_hit2;
  logic            w_ok1;
  logic            w_ok2;
  logic [XLEN-1:0] w_fdata1;
  logic [XLEN-1:0] w_fdata2;
  logic [XLEN-1:0] w_val1;
  logic [XLEN-1:0] w_val2;
  logic            w_hazard;
  logic            w_in_ready;

  logic                   r_valid;
  logic [XLEN-1:0]        r_pc;
  logic [31:0]            r_inst;
  logic [XLEN-1:0]        r_rs1_val;
  logic [XLEN-1:0]        r_rs2_val;
  logic                   r_trap;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_opcode = bus.in_inst[6:0];
  assign w_funct3 = bus.in_inst[14:12];
  assign w_rs1    = bus.in_inst[19:15];
  assign w_rs2    = bus.in_inst[24:20];
  assign bus.rs1  = w_rs1;
  assign bus.rs2  = w_rs2;

  // Decode which source operands the instruction consumes and whether it traps.
  always_comb begin
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    w_trap = 1'b0;
    case (w_opcode)
      OpLui, OpAuipc, OpJal: begin
      end
      OpJalr: begin
        w_use1 = 1'b1;
        w_trap = (w_funct3 != 3'd0);
      end
      OpBranch: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_trap = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
      end
      OpLoad: begin
        w_use1 = 1'b1;
        w_trap = (w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7);
      end
      OpStore: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_trap = (w_funct3 > 3'd2);
      end
      OpImm: w_use1 = 1'b1;
      OpReg: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      default: w_trap = 1'b1;
    endcase
  end

  // Find the youngest matching source per operand; scanning oldest-first lets
  // lower indices overwrite, so a not-ready younger match masks older ones.
  always_comb begin
    w_hit1   = 1'b0;
    w_hit2   = 1'b0;
    w_ok1    = 1'b0;
    w_ok2    = 1'b0;
    w_fdata1 = '0;
    w_fdata2 = '0;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (bus.fwd_valid[i] && bus.fwd_wb[i] && (bus.fwd_rd[i*5 +: 5] == w_rs1) &&
          (w_rs1 != 5'd0)) begin
        w_hit1   = 1'b1;
        w_ok1    = bus.fwd_data_ok[i];
        w_fdata1 = bus.fwd_data[i*XLEN +: XLEN];
      end
      if (bus.fwd_valid[i] && bus.fwd_wb[i] && (bus.fwd_rd[i*5 +: 5] == w_rs2) &&
          (w_rs2 != 5'd0)) begin
        w_hit2   = 1'b1;
        w_ok2    = bus.fwd_data_ok[i];
        w_fdata2 = bus.fwd_data[i*XLEN +: XLEN];
      end
    end
  end

  // Select operand values: x0 is hard zero, ready match beats the regfile.
  always_comb begin
    if (w_rs1 == 5'd0) begin
      w_val1 = '0;
    end else if (w_hit1 && w_ok1) begin
      w_val1 = w_fdata1;
    end else begin
      w_val1 = bus.reg_a;
    end
    if (w_rs2 == 5'd0) begin
      w_val2 = '0;
    end else if (w_hit2 && w_ok2) begin
      w_val2 = w_fdata2;
    end else begin
      w_val2 = bus.reg_b;
    end
  end

  assign w_hazard   = bus.in_valid && ((w_use1 && w_hit1 && !w_ok1) ||
                                       (w_use2 && w_hit2 && !w_ok2));
  assign w_in_ready = !w_hazard && (!r_valid || bus.out_ready) && !bus.flush;
  assign bus.in_ready = w_in_ready;

  // Output pipeline register: reset, flush, capture, drain, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_inst    <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_trap    <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (bus.in_valid && w_in_ready) begin
      r_valid   <= 1'b1;
      r_pc      <= bus.in_pc;
      r_inst    <= bus.in_inst;
      r_rs1_val <= w_val1;
      r_rs2_val <= w_val2;
      r_trap    <= w_trap;
    end else if (bus.out_ready && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  // Saturating count of hazard cycles; flushed cycles are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && !bus.flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign bus.out_valid   = r_valid;
  assign bus.out_pc      = r_pc;
  assign bus.out_inst    = r_inst;
  assign bus.out_rs1_val = r_rs1_val;
  assign bus.out_rs2_val = r_rs2_val;
  assign bus.out_trap    = r_trap;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage: forwarding, load-use stall, x0/unused
// operands, backpressure, flush, traps, counter saturation and reset.
module tb_id_fwd_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NFWD  = 3;
  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  id_fwd_stage_if #(.XLEN(XLEN), .NUM_FWD(NFWD), .STALL_CNT_W(CNT_W)) bus ();

  id_fwd_stage #(.XLEN(XLEN), .NUM_FWD(NFWD), .STALL_CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int idx, input logic v, input logic [4:0] rd,
                         input logic ok, input logic [31:0] data);
    bus.fwd_valid[idx]            = v;
    bus.fwd_wb[idx]               = v;
    bus.fwd_rd[idx*5 +: 5]        = rd;
    bus.fwd_data_ok[idx]          = ok;
    bus.fwd_data[idx*XLEN +: XLEN] = data;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  logic [31:0] lui_inst;
  logic [31:0] addi_inst;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.flush = 1'b0;
    bus.reg_a = '0; bus.reg_b = '0; bus.out_ready = 1'b1;
    bus.fwd_valid = '0; bus.fwd_wb = '0; bus.fwd_rd = '0; bus.fwd_data_ok = '0;
    bus.fwd_data = '0;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_valid", bus.out_valid, 0);
    check("rst_stall", bus.stall_cnt, 0);
    check("rst_inst", bus.out_inst, 0);

    // Back-to-back forwarding from source 0
    bus.in_valid = 1'b1; bus.in_inst = enc_r(5'd6, 5'd5, 5'd5); bus.in_pc = 32'h100;
    bus.reg_a = 32'h11; bus.reg_b = 32'h22;
    set_fwd(0, 1'b1, 5'd5, 1'b1, 32'd7);
    #1;
    check("rs1_addr", bus.rs1, 5);
    check("rs2_addr", bus.rs2, 5);
    check("fwd_in_ready", bus.in_ready, 1);
    cyc();
    check("fwd_valid", bus.out_valid, 1);
    check("fwd_rs1", bus.out_rs1_val, 7);
    check("fwd_rs2", bus.out_rs2_val, 7);
    check("fwd_pc", bus.out_pc, 32'h100);
    check("fwd_stall", bus.stall_cnt, 0);

    // Load-use: younger not-ready match masks older ready match
    bus.in_inst = enc_r(5'd7, 5'd5, 5'd0); bus.in_pc = 32'h104;
    set_fwd(0, 1'b1, 5'd5, 1'b0, 32'd0);
    set_fwd(1, 1'b1, 5'd5, 1'b1, 32'd9);
    #1;
    check("lu_in_ready", bus.in_ready, 0);
    cyc();
    check("lu_valid_drop", bus.out_valid, 0);
    check("lu_stall1", bus.stall_cnt, 1);
    check("lu_in_ready2", bus.in_ready, 0);
    cyc();
    check("lu_stall2", bus.stall_cnt, 2);
    set_fwd(0, 1'b1, 5'd5, 1'b1, 32'h55);
    #1;
    check("lu_ready_ok", bus.in_ready, 1);
    cyc();
    check("lu_valid", bus.out_valid, 1);
    check("lu_rs1", bus.out_rs1_val, 32'h55);
    check("lu_rs2_x0", bus.out_rs2_val, 0);
    check("lu_stall_keep", bus.stall_cnt, 2);

    // x0 reads zero even with a source writing rd=0
    set_fwd(1, 1'b0, 5'd0, 1'b0, 32'd0);
    set_fwd(0, 1'b1, 5'd0, 1'b1, 32'h1234);
    bus.in_inst = enc_r(5'd1, 5'd0, 5'd0); bus.in_pc = 32'h108;
    bus.reg_a = 32'hDEAD; bus.reg_b = 32'hBEEF;
    cyc();
    check("x0_rs1", bus.out_rs1_val, 0);
    check("x0_rs2", bus.out_rs2_val, 0);

    // lui ignores its not-ready rs1 field (inst[19:15]=5)
    lui_inst = {20'h00028, 5'd3, 7'b0110111};
    bus.in_inst = lui_inst; bus.in_pc = 32'h10C;
    set_fwd(0, 1'b1, 5'd5, 1'b0, 32'd0);
    #1;
    check("lui_rs1_addr", bus.rs1, 5);
    check("lui_in_ready", bus.in_ready, 1);
    cyc();
    check("lui_inst", bus.out_inst, lui_inst);
    check("lui_stall", bus.stall_cnt, 2);

    // Backpressure holds outputs
    bus.fwd_valid = '0; bus.fwd_wb = '0;
    addi_inst = enc_i(12'd1, 5'd0, 3'd0, 5'd8, 7'b0010011);
    bus.in_inst = addi_inst; bus.in_pc = 32'h200; bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", bus.in_ready, 0);
      cyc();
      check("bp_valid", bus.out_valid, 1);
      check("bp_inst", bus.out_inst, lui_inst);
      check("bp_pc", bus.out_pc, 32'h10C);
      check("bp_stall", bus.stall_cnt, 2);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release", bus.in_ready, 1);
    cyc();
    check("bp_new_inst", bus.out_inst, addi_inst);
    check("bp_new_pc", bus.out_pc, 32'h200);
    check("bp_new_valid", bus.out_valid, 1);

    // Flush during a hazard
    bus.in_inst = enc_r(5'd9, 5'd5, 5'd0); bus.in_pc = 32'h204;
    set_fwd(0, 1'b1, 5'd5, 1'b0, 32'd0);
    bus.flush = 1'b1; bus.out_ready = 1'b0;
    #1;
    check("fl_in_ready", bus.in_ready, 0);
    cyc();
    check("fl_valid", bus.out_valid, 0);
    check("fl_stall", bus.stall_cnt, 2);
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cyc();
    check("fl_not_accepted", bus.out_valid, 0);
    check("fl_inst_held", bus.out_inst, addi_inst);

    // Traps
    bus.fwd_valid = '0; bus.fwd_wb = '0; bus.in_valid = 1'b1;
    bus.in_inst = 32'h0000007F; bus.in_pc = 32'h300;
    cyc();
    check("trap_op_valid", bus.out_valid, 1);
    check("trap_op", bus.out_trap, 1);
    bus.in_inst = enc_i(12'd0, 5'd1, 3'd3, 5'd2, 7'b0000011);
    cyc();
    check("trap_ld_f3", bus.out_trap, 1);
    bus.in_inst = enc_i(12'd0, 5'd1, 3'd2, 5'd2, 7'b0000011);
    cyc();
    check("lw_ok", bus.out_trap, 0);
    bus.in_inst = enc_i(12'd0, 5'd1, 3'd1, 5'd1, 7'b1100111);
    cyc();
    check("trap_jalr", bus.out_trap, 1);

    // Counter saturation, then reset mid-stall
    bus.in_inst = enc_r(5'd10, 5'd5, 5'd0); bus.in_pc = 32'h400;
    set_fwd(0, 1'b1, 5'd5, 1'b0, 32'd0);
    for (int k = 0; k < 13; k++) cyc();
    check("sat_reach", bus.stall_cnt, 15);
    check("sat_valid", bus.out_valid, 0);
    for (int k = 0; k < 7; k++) cyc();
    check("sat_hold", bus.stall_cnt, 15);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst2_valid", bus.out_valid, 0);
    check("rst2_stall", bus.stall_cnt, 0);
    check("rst2_pc", bus.out_pc, 0);
    check("rst2_inst", bus.out_inst, 0);
    check("rst2_rs1", bus.out_rs1_val, 0);
    check("rst2_rs2", bus.out_rs2_val, 0);
    check("rst2_trap", bus.out_trap, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
